envelope_generator: RTL and testbench

AY-3-8913 envelope generator. It produces the 4-bit envelope amplitude that replaces a channel's fixed amplitude whenever that channel's R8/R9/R10 bit4 (envelope mode) is set. It sits directly upstream of the per-channel attenuation stage, replacing the constant envelope value of 15. Inputs are the R11/R12 period, the R13 shape bits, and a restart pulse generated by the register file on every write to R13.

---
 rtl/psg_pkg.sv | 22 ++
 rtl/envelope_generator.sv | 104 ++++++++++
 tb/tb_envelope_generator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/psg_pkg.sv
// Shared PSG constants: envelope step count, R13 shape bit positions and
// register addresses used by the register file to derive the envelope restart.
package psg_pkg;

  localparam int ENV_STEPS = 16;

  localparam int ENV_CONT = 3;
  localparam int ENV_ATT  = 2;
  localparam int ENV_ALT  = 1;
  localparam int ENV_HOLD = 0;

  localparam logic [3:0] R_ENV_FINE   = 4'd11;
  localparam logic [3:0] R_ENV_COARSE = 4'd12;
  localparam logic [3:0] R_ENV_SHAPE  = 4'd13;

  typedef struct packed {
    logic cont;
    logic alt;
    logic hold;
  } env_shape_t;

endpackage

// File: rtl/envelope_generator.sv
// AY-3-8913 envelope generator: 16-step ramp whose direction, repetition and
// hold behaviour follow the R13 shape latched on each restart.
module envelope_generator
  import psg_pkg::*;
#(
  parameter int PERIOD_BITS   = 16,
  parameter int ENVELOPE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PERIOD_BITS-1:0]   period,
  input  logic [3:0]               shape,
  input  logic                     restart,
  output logic [ENVELOPE_BITS-1:0] envelope_out,
  output logic                     holding
);

  localparam logic [3:0] LAST_STEP = 4'(ENV_STEPS - 1);

  logic [PERIOD_BITS-1:0]   cnt_q, cnt_d;
  logic [3:0]               step_q, step_d;
  logic                     att_q, att_d;
  env_shape_t               shape_q, shape_d;
  logic                     holding_q, holding_d;
  logic [ENVELOPE_BITS-1:0] env_q, env_d;

  // One extra bit so the increment and the 0->1 substitution never overflow.
  logic [PERIOD_BITS:0] period_eff;
  logic [PERIOD_BITS:0] cnt_inc;
  logic                 step_evt;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cnt_d      = cnt_q;
    step_d     = step_q;
    att_d      = att_q;
    shape_d    = shape_q;
    holding_d  = holding_q;
    step_evt   = 1'b0;
    period_eff = (period == '0) ? (PERIOD_BITS+1)'(1) : {1'b0, period};
    cnt_inc    = {1'b0, cnt_q} + (PERIOD_BITS+1)'(1);

    if (restart) begin
      cnt_d        = '0;
      step_d       = '0;
      att_d        = shape[ENV_ATT];
      shape_d.cont = shape[ENV_CONT];
      shape_d.alt  = shape[ENV_ALT];
      shape_d.hold = shape[ENV_HOLD];
      holding_d    = 1'b0;
    end else if (!holding_q) begin
      // >= so that shortening the period mid-step ends the step at once.
      if (cnt_inc >= period_eff) begin
        cnt_d    = '0;
        step_evt = 1'b1;
      end else begin
        cnt_d = cnt_inc[PERIOD_BITS-1:0];
      end

      if (step_evt) begin
        if (step_q != LAST_STEP) begin
          step_d = step_q + 4'd1;
        end else if (!shape_q.cont) begin
          step_d    = '0;
          att_d     = 1'b1;
          holding_d = 1'b1;
        end else if (shape_q.hold) begin
          att_d     = att_q ^ shape_q.alt;
          holding_d = 1'b1;
        end else begin
          step_d = '0;
          att_d  = att_q ^ shape_q.alt;
        end
      end
    end

    env_d = ENVELOPE_BITS'(att_d ? step_d : ~step_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      step_q    <= '0;
      att_q     <= 1'b1;
      shape_q   <= '0;
      holding_q <= 1'b1;
      env_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      att_q     <= att_d;
      shape_q   <= shape_d;
      holding_q <= holding_d;
      env_q     <= env_d;
    end
  end

  assign envelope_out = env_q;
  assign holding      = holding_q;

endmodule

// File: tb/tb_envelope_generator.sv
// Directed bench for envelope_generator: each task drives one scenario and
// compares the registered outputs against hand-derived sequences.
module tb_envelope_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] period;
  logic [3:0]  shape;
  logic        restart;
  logic [3:0]  envelope_out;
  logic        holding;

  int checks = 0;
  int errors = 0;

  envelope_generator #(.PERIOD_BITS(16), .ENVELOPE_BITS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .period       (period),
    .shape        (shape),
    .restart      (restart),
    .envelope_out (envelope_out),
    .holding      (holding)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart(input logic [3:0] shp);
    shape   = shp;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (envelope_out !== 4'd0 || holding !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d env=%0d hold=%0b expected env=0 hold=1",
                 i, envelope_out, holding);
      end
      tick();
    end
  endtask

  task automatic test_sawtooth();
    period = 16'd2;
    do_restart(4'b1100);
    for (int i = 0; i < 66; i++) begin
      logic [3:0] exp_v;
      exp_v = 4'((i / 2) % 16);
      checks++;
      if (envelope_out !== exp_v || holding !== 1'b0) begin
        errors++;
        $display("FAIL sawtooth i=%0d env=%0d hold=%0b expected env=%0d hold=0",
                 i, envelope_out, holding, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_triangle();
    period = 16'd1;
    do_restart(4'b1010);
    for (int i = 0; i < 48; i++) begin
      logic [3:0] exp_v;
      int pos;
      pos   = i % 16;
      exp_v = ((i / 16) % 2 == 0) ? 4'(15 - pos) : 4'(pos);
      checks++;
      if (envelope_out !== exp_v || holding !== 1'b0) begin
        errors++;
        $display("FAIL triangle i=%0d env=%0d hold=%0b expected env=%0d hold=0",
                 i, envelope_out, holding, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] shapes [3];
    logic [3:0] hold_v [3];
    shapes = '{4'b0000, 4'b1101, 4'b1111};
    hold_v = '{4'd0, 4'd15, 4'd0};
    period = 16'd0;
    for (int s = 0; s < 3; s++) begin
      do_restart(shapes[s]);
      for (int i = 0; i < 36; i++) begin
        logic [3:0] exp_v;
        logic       exp_h;
        if (i < 16) begin
          exp_v = (s == 0) ? 4'(15 - i) : 4'(i);
          exp_h = 1'b0;
        end else begin
          exp_v = hold_v[s];
          exp_h = 1'b1;
        end
        checks++;
        if (envelope_out !== exp_v || holding !== exp_h) begin
          errors++;
          $display("FAIL one_shot shape=%b i=%0d env=%0d hold=%0b expected env=%0d hold=%0b",
                   shapes[s], i, envelope_out, holding, exp_v, exp_h);
        end
        tick();
      end
    end
  endtask

  task automatic test_mid_ramp();
    period = 16'd4;
    do_restart(4'b1100);
    // Step 7 occupies samples 28..31; sample 31 is the last cycle before its step event.
    repeat (31) tick();
    checks++;
    if (envelope_out !== 4'd7) begin
      errors++;
      $display("FAIL mid_pre_restart env=%0d expected 7", envelope_out);
    end
    do_restart(4'b1100);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp_v;
      exp_v = (i < 4) ? 4'd0 : 4'd1;
      checks++;
      if (envelope_out !== exp_v) begin
        errors++;
        $display("FAIL restart_wins i=%0d env=%0d expected %0d", i, envelope_out, exp_v);
      end
      if (i < 4) tick();
    end
    // Now at sample 4; new shape must be ignored without a restart.
    shape = 4'b0000;
    repeat (60) tick();
    checks++;
    if (envelope_out !== 4'd0 || holding !== 1'b0) begin
      errors++;
      $display("FAIL shape_ignored env=%0d hold=%0b expected env=0 hold=0",
               envelope_out, holding);
    end
    tick();
    checks++;
    if (envelope_out !== 4'd0) begin
      errors++;
      $display("FAIL period_pre env=%0d expected 0", envelope_out);
    end
    period = 16'd1;
    tick();
    checks++;
    if (envelope_out !== 4'd1) begin
      errors++;
      $display("FAIL period_shrink env=%0d expected 1", envelope_out);
    end
    tick();
    checks++;
    if (envelope_out !== 4'd2) begin
      errors++;
      $display("FAIL period_after env=%0d expected 2", envelope_out);
    end
  endtask

  task automatic test_reset_mid_ramp();
    period = 16'd1;
    do_restart(4'b1100);
    repeat (9) tick();
    checks++;
    if (envelope_out !== 4'd9) begin
      errors++;
      $display("FAIL pre_reset env=%0d expected 9", envelope_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (envelope_out !== 4'd0 || holding !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid i=%0d env=%0d hold=%0b expected env=0 hold=1",
                 i, envelope_out, holding);
      end
      tick();
    end
    do_restart(4'b1000);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_v;
      exp_v = 4'(15 - i);
      checks++;
      if (envelope_out !== exp_v || holding !== 1'b0) begin
        errors++;
        $display("FAIL resume_decay i=%0d env=%0d hold=%0b expected env=%0d hold=0",
                 i, envelope_out, holding, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    reset   = 1'b0;
    period  = 16'd0;
    shape   = 4'd0;
    restart = 1'b0;
    #2;
    test_reset();
    test_sawtooth();
    test_triangle();
    test_one_shot();
    test_mid_ramp();
    test_reset_mid_ramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
